sevseg_scan_decoder: RTL and testbench

- Receive side of the multiplexed seven-segment interface: samples `anode_select`/`segs` as driven by the display driver and rebuilds the 32-bit hex value being shown.
- Digits are filtered for stability, decoded, and published once every anode has been seen.
- Used for on-board loopback self-test and as a bench monitor for the display path.
- Also reports illegal anode patterns, undecodable segment patterns, and a stalled scan.

---
 rtl/sevseg_pkg.sv | 45 ++++
 rtl/sevseg_scan_decoder_if.sv | 25 ++
 rtl/segments_to_digit.sv | 32 +++
 rtl/sevseg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_sevseg_scan_decoder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sevseg_pkg.sv
// Shared seven-segment definitions: active-high {g,f,e,d,c,b,a} patterns for
// the hex digits, the digit count of the display, and small helpers.
package sevseg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg_t;

    // One synchronized look at the display pins (both fields active-low).
    typedef struct packed {
        logic [NUM_DIGITS-1:0] anode_n;
        seg_t                  segs_n;
    } scan_sample_t;

    localparam seg_t SEG_HEX_0 = 7'h3F;
    localparam seg_t SEG_HEX_1 = 7'h06;
    localparam seg_t SEG_HEX_2 = 7'h5B;
    localparam seg_t SEG_HEX_3 = 7'h4F;
    localparam seg_t SEG_HEX_4 = 7'h66;
    localparam seg_t SEG_HEX_5 = 7'h6D;
    localparam seg_t SEG_HEX_6 = 7'h7D;
    localparam seg_t SEG_HEX_7 = 7'h07;
    localparam seg_t SEG_HEX_8 = 7'h7F;
    localparam seg_t SEG_HEX_9 = 7'h6F;
    localparam seg_t SEG_HEX_A = 7'h77;
    localparam seg_t SEG_HEX_B = 7'h7C;
    localparam seg_t SEG_HEX_C = 7'h39;
    localparam seg_t SEG_HEX_D = 7'h5E;
    localparam seg_t SEG_HEX_E = 7'h79;
    localparam seg_t SEG_HEX_F = 7'h71;

    // Indexed by nibble value; the encoder and the decoder both walk this.
    localparam seg_t SEG_TABLE [16] = '{
        SEG_HEX_0, SEG_HEX_1, SEG_HEX_2, SEG_HEX_3,
        SEG_HEX_4, SEG_HEX_5, SEG_HEX_6, SEG_HEX_7,
        SEG_HEX_8, SEG_HEX_9, SEG_HEX_A, SEG_HEX_B,
        SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
    };

    // True when exactly one bit of v is set.
    function automatic logic one_active(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/sevseg_scan_decoder_if.sv
// Display-side bundle: the multiplexed pins coming from the display driver
// and the rebuilt frame going to whoever consumes it.
interface sevseg_scan_decoder_if;
    import sevseg_pkg::*;

    logic [NUM_DIGITS-1:0]   anode_select;
    seg_t                    segs;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   bad_digit;
    logic                    frame_valid;
    logic                    anode_error;
    logic                    stale;

    // Display driver side (or a bench standing in for it).
    modport master (
        output anode_select, segs,
        input  digits, bad_digit, frame_valid, anode_error, stale
    );

    // Scan decoder side.
    modport slave (
        input  anode_select, segs,
        output digits, bad_digit, frame_valid, anode_error, stale
    );
endinterface

// File: rtl/segments_to_digit.sv
// Combinational inverse of the digit-to-segment encoder: maps an active-high
// segment pattern back to its nibble, flagging patterns outside the hex set.
module segments_to_digit
    import sevseg_pkg::*;
(
    input  seg_t       i_seg,
    output logic [3:0] o_nibble,
    output logic       o_valid
);

    logic [15:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cmp
            assign w_match[gi] = (i_seg == SEG_TABLE[gi]);
        end
    endgenerate

    // Table entries are all distinct, so at most one match bit is ever set.
    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (w_match[k]) begin
                o_nibble = 4'(k);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Receive side of the multiplexed seven-segment display: synchronizes the
// pins, waits for each pattern to settle, decodes digits into a shadow frame
// and publishes it once every anode has been seen. Also flags bad anode
// patterns, undecodable digits and a stalled scan.
module sevseg_scan_decoder
    import sevseg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    sevseg_scan_decoder_if.slave bus
);

    localparam int CNT_W   = 8;
    localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]   SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   SETTLE_PRE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(TIMEOUT_CYCLES);

    // Idle pins: all anodes off, all segments off. Resetting the synchronizer
    // here means the first thing ever accepted is a harmless blanking sample.
    localparam scan_sample_t IDLE_SAMPLE = '{anode_n: '1, segs_n: '1};

    scan_sample_t            r_sync1;
    scan_sample_t            r_sync2;
    scan_sample_t            r_prev;
    logic [CNT_W-1:0]        r_settle_cnt;
    logic [3:0]              r_shadow     [NUM_DIGITS];
    logic                    r_bad_shadow [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   r_seen;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_bad_digit;
    logic                    r_frame_valid;
    logic                    r_anode_error;
    logic [STALE_W-1:0]      r_stale_cnt;

    scan_sample_t            w_pin_sample;
    logic                    w_same;
    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_anode_low;
    logic                    w_blank;
    logic                    w_single;
    logic                    w_take_digit;
    logic                    w_multi;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_publish;
    seg_t                    w_seg_hi;
    logic [3:0]              w_digit_nibble;
    logic                    w_digit_valid;
    logic [3:0]              w_digit_value;
    logic [4*NUM_DIGITS-1:0] w_frame_digits;
    logic [NUM_DIGITS-1:0]   w_frame_bad;

    assign w_pin_sample = '{anode_n: bus.anode_select, segs_n: bus.segs};

    // Two-flop synchronizer on all display pins together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= IDLE_SAMPLE;
            r_sync2 <= IDLE_SAMPLE;
        end else begin
            r_sync1 <= w_pin_sample;
            r_sync2 <= r_sync1;
        end
    end

    assign w_same = (r_sync2 == r_prev);

    // Count consecutive identical samples, saturating so each stable period
    // yields one accept only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev       <= IDLE_SAMPLE;
            r_settle_cnt <= '0;
        end else begin
            r_prev <= r_sync2;
            if (!w_same) begin
                r_settle_cnt <= CNT_W'(1);
            end else if (r_settle_cnt != SETTLE_MAX) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
            end
        end
    end

    // Fires on the SETTLE_CYCLES-th identical sample.
    assign w_accept     = w_same && (r_settle_cnt == SETTLE_PRE);

    assign w_anode_low  = ~r_sync2.anode_n;
    assign w_blank      = (w_anode_low == '0);
    assign w_single     = one_active(w_anode_low);
    assign w_take_digit = w_accept && w_single;
    assign w_multi      = w_accept && !w_blank && !w_single;
    assign w_seen_next  = r_seen | w_anode_low;
    assign w_publish    = w_take_digit && (w_seen_next == '1);

    assign w_seg_hi = ~r_sync2.segs_n;

    segments_to_digit u_decode (
        .i_seg    (w_seg_hi),
        .o_nibble (w_digit_nibble),
        .o_valid  (w_digit_valid)
    );

    // Undecodable digits are stored as zero and flagged separately.
    assign w_digit_value = w_digit_valid ? w_digit_nibble : 4'h0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic w_hit;
            assign w_hit = w_take_digit && w_anode_low[gi];

            // Frame as it would be published now, with the incoming digit merged.
            assign w_frame_digits[4*gi +: 4] = w_hit ? w_digit_value  : r_shadow[gi];
            assign w_frame_bad[gi]           = w_hit ? !w_digit_valid : r_bad_shadow[gi];

            // Latest accepted value for this anode wins until the frame publishes.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_shadow[gi]     <= 4'h0;
                    r_bad_shadow[gi] <= 1'b0;
                end else if (w_hit) begin
                    r_shadow[gi]     <= w_digit_value;
                    r_bad_shadow[gi] <= !w_digit_valid;
                end
            end
        end
    endgenerate

    // Track which anodes have contributed to the frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seen <= '0;
        end else if (w_publish) begin
            r_seen <= '0;
        end else if (w_take_digit) begin
            r_seen <= w_seen_next;
        end
    end

    // Published frame plus the one-cycle status pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_digits      <= '0;
            r_bad_digit   <= '0;
            r_frame_valid <= 1'b0;
            r_anode_error <= 1'b0;
        end else begin
            r_frame_valid <= w_publish;
            r_anode_error <= w_multi;
            if (w_publish) begin
                r_digits    <= w_frame_digits;
                r_bad_digit <= w_frame_bad;
            end
        end
    end

    // Cycles since the last publish, saturating at the timeout.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stale_cnt <= '0;
        end else if (w_publish) begin
            r_stale_cnt <= '0;
        end else if (r_stale_cnt != STALE_MAX) begin
            r_stale_cnt <= r_stale_cnt + STALE_W'(1);
        end
    end

    assign bus.digits      = r_digits;
    assign bus.bad_digit   = r_bad_digit;
    assign bus.frame_valid = r_frame_valid;
    assign bus.anode_error = r_anode_error;
    assign bus.stale       = (r_stale_cnt == STALE_MAX);

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Bench for sevseg_scan_decoder: drives scan patterns at the pins and checks
// published frames against a model that only knows "a pattern held for at
// least SETTLE cycles is accepted" plus the hex segment table.
module tb_sevseg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sevseg_scan_decoder_if bus ();

    sevseg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] obs_d[$];
    logic [7:0]  obs_b[$];
    logic [31:0] exp_d[$];
    logic [7:0]  exp_b[$];
    int          ae_count = 0;
    logic        fv_prev = 1'b0;
    logic        stale_after_fv = 1'b1;

    logic [3:0]  m_val [8];
    logic        m_bad [8];
    logic [7:0]  m_seen;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (fv_prev) stale_after_fv = bus.stale;
        fv_prev = (bus.frame_valid === 1'b1);
        if (bus.frame_valid === 1'b1) begin
            obs_d.push_back(bus.digits);
            obs_b.push_back(bus.bad_digit);
        end
        if (bus.anode_error === 1'b1) ae_count++;
    end

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic int decode(input logic [6:0] hi);
        for (int n = 0; n < 16; n++) if (hex_seg(4'(n)) == hi) return n;
        return -1;
    endfunction

    task automatic model_clear();
        m_seen = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_val[i] = 4'h0;
            m_bad[i] = 1'b0;
        end
        exp_d.delete(); exp_b.delete();
        obs_d.delete(); obs_b.delete();
    endtask

    task automatic model_accept(input int idx, input logic [6:0] sg_n);
        int n;
        logic [31:0] d;
        logic [7:0]  b;
        n = decode(~sg_n);
        m_val[idx]  = (n < 0) ? 4'h0 : 4'(n);
        m_bad[idx]  = (n < 0);
        m_seen[idx] = 1'b1;
        if (m_seen == 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                d[4*i +: 4] = m_val[i];
                b[i]        = m_bad[i];
            end
            exp_d.push_back(d);
            exp_b.push_back(b);
            m_seen = 8'h00;
        end
    endtask

    // Called at posedge+1; holds the pattern across len rising edges.
    task automatic put(input logic [7:0] an, input logic [6:0] sg, input int len);
        bus.anode_select = an;
        bus.segs         = sg;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] sg_n, input int len);
        logic [7:0] an;
        an = 8'h01 << idx;
        put(~an, sg_n, len);
        if (len >= SETTLE) model_accept(idx, sg_n);
    endtask

    task automatic flush();
        put(8'hFF, 7'h7F, SETTLE + 6);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        put(8'hFF, 7'h7F, 3);
        rst_n = 1'b1;
        model_clear();
        ae_count = 0;
    endtask

    task automatic test_reset();
        bus.anode_select = 8'hFF;
        bus.segs         = 7'h7F;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.digits !== 32'h0)      begin failures++; $display("FAIL reset_digits got=%h want=0", bus.digits); end
        checks++; if (bus.bad_digit !== 8'h0)    begin failures++; $display("FAIL reset_bad got=%h want=0", bus.bad_digit); end
        checks++; if (bus.frame_valid !== 1'b0)  begin failures++; $display("FAIL reset_fv got=%b want=0", bus.frame_valid); end
        checks++; if (bus.anode_error !== 1'b0)  begin failures++; $display("FAIL reset_ae got=%b want=0", bus.anode_error); end
        checks++; if (bus.stale !== 1'b0)        begin failures++; $display("FAIL reset_stale got=%b want=0", bus.stale); end
        $display("reset: outputs digits=%h bad=%h stale=%b", bus.digits, bus.bad_digit, bus.stale);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_stale();
        logic [31:0] val;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checks++; if (bus.stale !== 1'b0) begin failures++; $display("FAIL stale_early got=%b want=0", bus.stale); end
        @(posedge clk); #1;
        checks++; if (bus.stale !== 1'b1) begin failures++; $display("FAIL stale_rise got=%b want=1", bus.stale); end
        $display("stale: at cycle %0d stale=%b", TIMEOUT, bus.stale);
        stale_after_fv = 1'b1;
        val = $urandom;
        for (int i = 0; i < 8; i++) begin
            drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 2);
            put(8'hFF, 7'h7F, 1);
        end
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL stale_frames got=%0d want=1", obs_d.size()); end
        checks++; if (stale_after_fv !== 1'b0) begin failures++; $display("FAIL stale_clear got=%b want=0", stale_after_fv); end
        checks++; if (bus.stale !== 1'b0) begin failures++; $display("FAIL stale_after got=%b want=0", bus.stale); end
        $display("stale: after frame stale=%b", bus.stale);
    endtask

    task automatic test_loopback();
        logic [31:0] val;
        val = 32'h89AB_CDEF;
        obs_d.delete(); obs_b.delete(); exp_d.delete(); exp_b.delete();
        for (int i = 0; i < 8; i++) begin
            drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 2);
            put(8'hFF, 7'h7F, 1);
        end
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL loop_frames got=%0d want=1", obs_d.size()); end
        checks++; if (bus.digits !== 32'h89AB_CDEF) begin failures++; $display("FAIL loop_digits got=%h want=89abcdef", bus.digits); end
        checks++; if (bus.bad_digit !== 8'h00) begin failures++; $display("FAIL loop_bad got=%h want=00", bus.bad_digit); end
        $display("loopback: digits=%h bad=%h", bus.digits, bus.bad_digit);
    endtask

    task automatic test_random();
        int idx, len;
        logic [6:0] sg, x;
        obs_d.delete(); obs_b.delete(); exp_d.delete(); exp_b.delete();
        for (int s = 0; s < 120; s++) begin
            idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : (s % 8);
            if ($urandom_range(0, 7) == 0) begin
                do sg = 7'($urandom); while (decode(~sg) >= 0);
            end else begin
                sg = ~hex_seg(4'($urandom_range(0, 15)));
            end
            len = $urandom_range(SETTLE - 1, SETTLE + 2);
            drive_digit(idx, sg, len);
            if ($urandom_range(0, 1) == 1) begin
                do x = 7'($urandom); while (x == 7'h00);
                drive_digit(idx, sg ^ x, $urandom_range(1, SETTLE - 1));
            end
            put(8'hFF, 7'h7F, 1);
        end
        flush();
        checks++;
        if (obs_d.size() !== exp_d.size()) begin
            failures++; $display("FAIL rand_count got=%0d want=%0d", obs_d.size(), exp_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_b[k] !== exp_b[k]) begin
                failures++;
                $display("FAIL rand_frame%0d got=%h/%h want=%h/%h", k, obs_d[k], obs_b[k], exp_d[k], exp_b[k]);
            end else begin
                $display("random: frame %0d digits=%h bad=%h", k, obs_d[k], obs_b[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] val;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            val = $urandom;
            for (int i = 0; i < 8; i++) drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 1);
        end
        flush();
        checks++;
        if (obs_d.size() !== 2 || exp_d.size() !== 2) begin
            failures++; $display("FAIL b2b_count got=%0d want=2", obs_d.size());
        end
        for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
            checks++;
            if (obs_d[k] !== exp_d[k] || obs_b[k] !== exp_b[k]) begin
                failures++;
                $display("FAIL b2b_frame%0d got=%h/%h want=%h/%h", k, obs_d[k], obs_b[k], exp_d[k], exp_b[k]);
            end else begin
                $display("back_to_back: frame %0d digits=%h", k, obs_d[k]);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        drive_digit(0, 7'h40, 2);
        drive_digit(0, 7'h79, 10);
        for (int i = 1; i < 8; i++) begin
            put(8'hFF, 7'h7F, 1);
            drive_digit(i, 7'h40, SETTLE + 1);
        end
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL glitch_frames got=%0d want=1", obs_d.size()); end
        checks++; if (bus.digits !== 32'h0000_0001) begin failures++; $display("FAIL glitch_digits got=%h want=00000001", bus.digits); end
        $display("glitch: digits=%h", bus.digits);
    endtask

    task automatic test_bad_pattern();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_digit(i, (i == 3) ? 7'h7F : 7'h40, SETTLE + 2);
            put(8'hFF, 7'h7F, 1);
        end
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL bad_frames got=%0d want=1", obs_d.size()); end
        checks++; if (bus.digits !== 32'h0) begin failures++; $display("FAIL bad_digits got=%h want=0", bus.digits); end
        checks++; if (bus.bad_digit !== 8'h08) begin failures++; $display("FAIL bad_flags got=%h want=08", bus.bad_digit); end
        $display("bad_pattern: digits=%h bad=%h", bus.digits, bus.bad_digit);
    endtask

    task automatic test_anode_error();
        logic [31:0] val;
        do_reset();
        val = $urandom;
        for (int i = 0; i < 4; i++) begin
            drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 2);
            put(8'hFF, 7'h7F, 1);
        end
        put(8'hFC, 7'($urandom), 10);
        put(8'hFF, 7'h7F, SETTLE + 4);
        checks++; if (ae_count !== 1) begin failures++; $display("FAIL ae_pulses got=%0d want=1", ae_count); end
        checks++; if (obs_d.size() !== 0) begin failures++; $display("FAIL ae_no_frame got=%0d want=0", obs_d.size()); end
        for (int i = 4; i < 8; i++) begin
            drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 2);
            put(8'hFF, 7'h7F, 1);
        end
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL ae_frames got=%0d want=1", obs_d.size()); end
        checks++; if (bus.digits !== val) begin failures++; $display("FAIL ae_digits got=%h want=%h", bus.digits, val); end
        $display("anode_error: pulses=%0d digits=%h", ae_count, bus.digits);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] val;
        do_reset();
        val = $urandom | 32'h1111_1111;
        for (int i = 0; i < 8; i++) drive_digit(i, ~hex_seg(val[4*i +: 4]), SETTLE + 1);
        for (int i = 0; i < 5; i++) drive_digit(i, ~hex_seg(4'(i + 3)), SETTLE + 1);
        flush();
        checks++; if (bus.digits !== val) begin failures++; $display("FAIL mid_pre got=%h want=%h", bus.digits, val); end
        #3 rst_n = 1'b0;
        #2;
        checks++; if (bus.digits !== 32'h0)     begin failures++; $display("FAIL mid_digits got=%h want=0", bus.digits); end
        checks++; if (bus.bad_digit !== 8'h0)   begin failures++; $display("FAIL mid_bad got=%h want=0", bus.bad_digit); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL mid_fv got=%b want=0", bus.frame_valid); end
        checks++; if (bus.stale !== 1'b0)       begin failures++; $display("FAIL mid_stale got=%b want=0", bus.stale); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        for (int i = 1; i < 8; i++) drive_digit(i, ~hex_seg(4'(i)), SETTLE + 1);
        flush();
        checks++; if (obs_d.size() !== 0) begin failures++; $display("FAIL mid_early got=%0d want=0", obs_d.size()); end
        drive_digit(0, ~hex_seg(4'h9), SETTLE + 1);
        flush();
        checks++; if (obs_d.size() !== 1) begin failures++; $display("FAIL mid_frames got=%0d want=1", obs_d.size()); end
        checks++; if (bus.digits !== 32'h7654_3219) begin failures++; $display("FAIL mid_value got=%h want=76543219", bus.digits); end
        $display("reset_mid_frame: digits=%h", bus.digits);
    endtask

    initial begin
        test_reset();
        test_stale();
        test_loopback();
        test_random();
        test_back_to_back();
        test_glitch();
        test_bad_pattern();
        test_anode_error();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
